// File: rtl/ps2_player_input_if.sv
// Keyboard-to-game bus for ps2_player_input: scan-code strobe in, per-player
// direction levels and fire request/acknowledge handshakes out.
interface ps2_player_input_if;
    logic       clear;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic [3:0] p1_dir;
    logic [3:0] p2_dir;
    logic       p1_fire_req;
    logic       p1_fire_ack;
    logic       p2_fire_req;
    logic       p2_fire_ack;
    logic       prefix_err;

    modport master (
        output clear, scan_code, scan_code_ready, p1_fire_ack, p2_fire_ack,
        input  p1_dir, p2_dir, p1_fire_req, p2_fire_req, prefix_err
    );

    modport slave (
        input  clear, scan_code, scan_code_ready, p1_fire_ack, p2_fire_ack,
        output p1_dir, p2_dir, p1_fire_req, p2_fire_req, prefix_err
    );
endinterface

// File: rtl/ps2_player_input.sv
// PS/2 make/break decoder keeping a held-key map for two players.
// Optional macro PREFIX_TIMEOUT_EN aborts a stalled E0/F0 prefix after TIMEOUT_CYCLES.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no prefix pending; next byte is a plain make
// ST_EXT     | E0 seen; next byte is an extended make (or F0)
// ST_BRK     | F0 seen; next byte is a plain break
// ST_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_player_input #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input logic              clock,
    input logic              resetn,
    ps2_player_input_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    state_t      state_q, state_d;
    logic        key_make, key_break, key_ext;
    logic        timeout;
    logic [9:0]  key_hit;
    logic [9:0]  held_q, held_d;
    logic [7:0]  dir_q;
    logic        p1_fire_q, p2_fire_q;
    logic        p1_set, p2_set;

    // Held-map bit order: [3:0] p1 {up,down,left,right}, [7:4] p2, [8] Enter, [9] Space
    function automatic logic [3:0] cancel_opposing(input logic [3:0] h);
        logic [3:0] r;
        r = h;
        if (h[3] && h[2]) r[3:2] = 2'b00;
        if (h[1] && h[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        key_make  = 1'b0;
        key_break = 1'b0;
        key_ext   = 1'b0;
        if (bus.scan_code_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.scan_code == 8'hE0)      state_d = ST_EXT;
                    else if (bus.scan_code == 8'hF0) state_d = ST_BRK;
                    else                             key_make = 1'b1;
                end
                ST_EXT: begin
                    if (bus.scan_code == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.scan_code != 8'hE0) begin
                        key_make = 1'b1;
                        key_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    key_break = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    key_break = 1'b1;
                    key_ext   = 1'b1;
                    state_d   = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)        state_q <= ST_IDLE;
        else if (bus.clear) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        key_hit = 10'd0;
        if (key_ext) begin
            case (bus.scan_code)
                8'h75:   key_hit[3] = 1'b1;
                8'h72:   key_hit[2] = 1'b1;
                8'h6B:   key_hit[1] = 1'b1;
                8'h74:   key_hit[0] = 1'b1;
                default: key_hit = 10'd0;
            endcase
        end else begin
            case (bus.scan_code)
                8'h1D:   key_hit[7] = 1'b1;
                8'h1B:   key_hit[6] = 1'b1;
                8'h1C:   key_hit[5] = 1'b1;
                8'h23:   key_hit[4] = 1'b1;
                8'h5A:   key_hit[8] = 1'b1;
                8'h29:   key_hit[9] = 1'b1;
                default: key_hit = 10'd0;
            endcase
        end
    end

    always_comb begin
        held_d = held_q;
        if (key_make)  held_d = held_q | key_hit;
        if (key_break) held_d = held_q & ~key_hit;
    end

    // Only a fresh press arms fire; typematic repeats arrive with the bit already held
    assign p1_set = key_make && key_hit[8] && !held_q[8];
    assign p2_set = key_make && key_hit[9] && !held_q[9];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_q    <= 10'd0;
            dir_q     <= 8'd0;
            p1_fire_q <= 1'b0;
            p2_fire_q <= 1'b0;
        end else if (bus.clear) begin
            held_q    <= 10'd0;
            dir_q     <= 8'd0;
            p1_fire_q <= 1'b0;
            p2_fire_q <= 1'b0;
        end else begin
            held_q    <= held_d;
            dir_q     <= {cancel_opposing(held_q[7:4]), cancel_opposing(held_q[3:0])};
            if (p1_set)               p1_fire_q <= 1'b1;
            else if (bus.p1_fire_ack) p1_fire_q <= 1'b0;
            if (p2_set)               p2_fire_q <= 1'b1;
            else if (bus.p2_fire_ack) p2_fire_q <= 1'b0;
        end
    end

`ifdef PREFIX_TIMEOUT_EN
    logic [19:0] cnt_q;
    logic        err_q;

    // A strobe on the expiry cycle wins, so no byte is lost to the abort
    assign timeout = (state_q != ST_IDLE) && !bus.scan_code_ready && !bus.clear &&
                     (cnt_q == TIMEOUT_CYCLES - 20'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 20'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (bus.clear || bus.scan_code_ready || state_q == ST_IDLE || timeout)
                cnt_q <= 20'd0;
            else
                cnt_q <= cnt_q + 20'd1;
        end
    end

    assign bus.prefix_err = err_q;
`else
    wire unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign bus.prefix_err = 1'b0;
`endif

    assign bus.p1_dir      = dir_q[3:0];
    assign bus.p2_dir      = dir_q[7:4];
    assign bus.p1_fire_req = p1_fire_q;
    assign bus.p2_fire_req = p2_fire_q;
endmodule

// File: tb/tb_ps2_player_input.sv
// Self-checking bench for ps2_player_input: directed vector table, hand-written
// handshake/clear/reset/prefix-timeout sequences, then random traffic vs a model.
module tb_ps2_player_input;
    localparam int TMO = 16;

    logic clock;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    ps2_player_input_if bus ();

    ps2_player_input #(.TIMEOUT_CYCLES(20'd16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [7:0] code;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       f1;
        logic       f2;
    } vec_t;

    vec_t vecs [18];

    // Reference model state: pending-prefix flags instead of a state machine
    bit       m_ext, m_brk;
    bit [9:0] m_held;
    bit [3:0] m_p1, m_p2;
    bit       m_f1, m_f2, m_err;
    int       m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] code);
        bus.scan_code       = code;
        bus.scan_code_ready = 1'b1;
        step();
        bus.scan_code_ready = 1'b0;
    endtask

    function automatic int key_of(input bit ext, input logic [7:0] code);
        if (ext) begin
            if (code == 8'h75) return 3;
            if (code == 8'h72) return 2;
            if (code == 8'h6B) return 1;
            if (code == 8'h74) return 0;
            return -1;
        end
        if (code == 8'h1D) return 7;
        if (code == 8'h1B) return 6;
        if (code == 8'h1C) return 5;
        if (code == 8'h23) return 4;
        if (code == 8'h5A) return 8;
        if (code == 8'h29) return 9;
        return -1;
    endfunction

    function automatic bit [3:0] dir_view(input bit [3:0] h);
        bit [3:0] r;
        r = h;
        if (h[3] && h[2]) r[3:2] = 2'b00;
        if (h[1] && h[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = '0; m_p1 = '0; m_p2 = '0;
        m_f1 = 0; m_f2 = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit clr, input bit rdy, input logic [7:0] code,
                              input bit a1, input bit a2);
        int  mk, bk;
        bit  timed;
        bit [3:0] n1, n2;
        if (clr) begin
            model_reset();
            return;
        end
        n1 = dir_view(m_held[3:0]);
        n2 = dir_view(m_held[7:4]);
        mk = -1; bk = -1; timed = 0;
        if (rdy) begin
            m_cnt = 0;
            if (m_brk) begin
                bk = key_of(m_ext, code);
                m_ext = 0; m_brk = 0;
            end else if (code == 8'hE0) begin
                m_ext = 1;
            end else if (code == 8'hF0) begin
                m_brk = 1;
            end else begin
                mk = key_of(m_ext, code);
                m_ext = 0;
            end
        end
`ifdef PREFIX_TIMEOUT_EN
        else if (m_ext || m_brk) begin
            if (m_cnt == TMO - 1) begin
                m_ext = 0; m_brk = 0; m_cnt = 0; timed = 1;
            end else begin
                m_cnt++;
            end
        end
`endif
        m_err = timed;
        if (mk == 8 && !m_held[8]) m_f1 = 1; else if (a1) m_f1 = 0;
        if (mk == 9 && !m_held[9]) m_f2 = 1; else if (a2) m_f2 = 0;
        if (mk >= 0) m_held[mk] = 1'b1;
        if (bk >= 0) m_held[bk] = 1'b0;
        m_p1 = n1;
        m_p2 = n2;
    endtask

    initial begin
        int first_err, pulses;
        vecs[0]  = '{8'h1D, 4'b0000, 4'b1000, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 4'b0000, 4'b1000, 1'b0, 1'b0};
        vecs[2]  = '{8'h1D, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{8'hE0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{8'h75, 4'b1000, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{8'hE0, 4'b1000, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{8'h72, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{8'hE0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{8'hF0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{8'h75, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{8'h75, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vecs[11] = '{8'h1C, 4'b0100, 4'b0010, 1'b0, 1'b0};
        vecs[12] = '{8'h23, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{8'hF0, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{8'h1C, 4'b0100, 4'b0001, 1'b0, 1'b0};
        vecs[15] = '{8'h5A, 4'b0100, 4'b0001, 1'b1, 1'b0};
        vecs[16] = '{8'h5A, 4'b0100, 4'b0001, 1'b1, 1'b0};
        vecs[17] = '{8'h5A, 4'b0100, 4'b0001, 1'b1, 1'b0};

        resetn = 1'b0;
        bus.clear = 1'b0; bus.scan_code = 8'h00; bus.scan_code_ready = 1'b0;
        bus.p1_fire_ack = 1'b0; bus.p2_fire_ack = 1'b0;
        step(); step();
        check("reset outputs", {bus.p1_dir, bus.p2_dir, bus.p1_fire_req, bus.p2_fire_req, bus.prefix_err}, '0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            strobe(vecs[i].code);
            step();
            check($sformatf("vec%0d p1_dir", i), bus.p1_dir, vecs[i].p1);
            check($sformatf("vec%0d p2_dir", i), bus.p2_dir, vecs[i].p2);
            check($sformatf("vec%0d fire", i), {bus.p1_fire_req, bus.p2_fire_req}, {vecs[i].f1, vecs[i].f2});
        end

        // p1 fire acknowledge and re-arm after release
        bus.p1_fire_ack = 1'b1; step(); bus.p1_fire_ack = 1'b0;
        check("p1 ack clears", bus.p1_fire_req, 1'b0);
        step();
        check("p1 stays clear", bus.p1_fire_req, 1'b0);
        strobe(8'h5A);
        check("p1 repeat no rearm", bus.p1_fire_req, 1'b0);
        strobe(8'hF0); strobe(8'h5A);
        check("p1 break keeps clear", bus.p1_fire_req, 1'b0);
        strobe(8'h5A);
        check("p1 new press", bus.p1_fire_req, 1'b1);

        // p2 fire: new press and ack in the same cycle, press wins
        strobe(8'h29);
        check("p2 press", bus.p2_fire_req, 1'b1);
        strobe(8'hF0); strobe(8'h29);
        check("p2 break keeps req", bus.p2_fire_req, 1'b1);
        bus.scan_code = 8'h29; bus.scan_code_ready = 1'b1; bus.p2_fire_ack = 1'b1;
        step();
        bus.scan_code_ready = 1'b0;
        check("p2 set beats ack", bus.p2_fire_req, 1'b1);
        step();
        bus.p2_fire_ack = 1'b0;
        check("p2 ack alone", bus.p2_fire_req, 1'b0);

        // clear with a coincident strobe
        strobe(8'h1D); step();
        check("W+D held", bus.p2_dir, 4'b1001);
        bus.scan_code = 8'h1C; bus.scan_code_ready = 1'b1; bus.clear = 1'b1;
        step();
        bus.scan_code_ready = 1'b0; bus.clear = 1'b0;
        check("clear outputs", {bus.p1_dir, bus.p2_dir, bus.p1_fire_req, bus.p2_fire_req}, '0);
        strobe(8'h23); step();
        check("clear dropped 1C", bus.p2_dir, 4'b0001);
        strobe(8'h5A);
        check("clear released Enter", bus.p1_fire_req, 1'b1);

        // asynchronous reset in the middle of an extended prefix
        strobe(8'hE0); strobe(8'h75); step();
        check("p1 up before reset", bus.p1_dir, 4'b1000);
        strobe(8'hE0);
        #2 resetn = 1'b0;
        #1;
        check("async reset outputs", {bus.p1_dir, bus.p2_dir, bus.p1_fire_req, bus.p2_fire_req, bus.prefix_err}, '0);
        step();
        resetn = 1'b1;
        step();
        strobe(8'h75); step();
        check("prefix lost on reset", {bus.p1_dir, bus.p2_dir}, 8'h00);

        // stalled extended prefix
        strobe(8'hE0);
        first_err = -1; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.prefix_err === 1'b1) begin
                pulses++;
                if (first_err < 0) first_err = i;
            end
        end
`ifdef PREFIX_TIMEOUT_EN
        check("timeout pulse cycle", first_err, TMO);
        check("timeout pulse count", pulses, 1);
        strobe(8'h1D); step();
        check("after timeout plain make", bus.p2_dir, 4'b1000);
`else
        check("no prefix_err", pulses, 0);
        strobe(8'h75); step();
        check("prefix waits", bus.p1_dir, 4'b1000);
`endif

        // random traffic against the model
        bus.clear = 1'b1; step(); bus.clear = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] pool [14];
            bit clr, rdy, a1, a2;
            logic [7:0] code;
            pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D,
                     8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h29, 8'h12, 8'hE0};
            clr  = ($urandom % 80) == 0;
            rdy  = ($urandom % 2) == 0;
            if (n >= 1500 && n < 1600) rdy = ($urandom % 40) == 0;
            a1   = ($urandom % 4) == 0;
            a2   = ($urandom % 4) == 0;
            code = pool[$urandom % 14];
            bus.clear = clr; bus.scan_code_ready = rdy; bus.scan_code = code;
            bus.p1_fire_ack = a1; bus.p2_fire_ack = a2;
            step();
            model_edge(clr, rdy, code, a1, a2);
            check($sformatf("rand%0d outputs", n),
                  {bus.p1_dir, bus.p2_dir, bus.p1_fire_req, bus.p2_fire_req, bus.prefix_err},
                  {m_p1, m_p2, m_f1, m_f2, m_err});
        end
        bus.clear = 1'b0; bus.scan_code_ready = 1'b0;
        bus.p1_fire_ack = 1'b0; bus.p2_fire_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
